// File: rtl/rv_pipe_pkg.sv
// Shared pipeline definitions: default widths, the PC increment, and the
// bit layout of a fetch/decode/execute stage record {valid, pc, pred}.
package rv_pipe_pkg;

  localparam int DEF_AWIDTH = 32;
  localparam int DEF_CWIDTH = 16;
  localparam int PC_INC     = 4;

  // Index of each statistics counter in the counter bank.
  typedef enum logic [0:0] {
    CNT_BR  = 1'b0,
    CNT_MIS = 1'b1
  } cnt_sel_e;

  localparam int NUM_CNT = 2;

  // Default-width view of a stage record, handy for tooling and debug.
  typedef struct packed {
    logic                  v;
    logic [DEF_AWIDTH-1:0] pc;
    logic [DEF_AWIDTH-1:0] pred;
  } stage_t;

  // Stage record layout for an arbitrary address width:
  //   [2*aw]          valid
  //   [2*aw-1 : aw]   pc
  //   [aw-1   : 0]    predicted next pc
  function automatic int stage_width(input int aw);
    return 2 * aw + 1;
  endfunction

  function automatic int stage_v_bit(input int aw);
    return 2 * aw;
  endfunction

  function automatic int stage_pc_lsb(input int aw);
    return aw;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts qualifying edges and sticks at all-ones.
module sat_counter #(
  parameter int CWIDTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  output logic [CWIDTH-1:0] count
);

  logic [CWIDTH-1:0] count_reg;
  logic [CWIDTH-1:0] count_next;

  // Advance by one unless already saturated.
  always_comb begin
    count_next = count_reg;
    if (inc && (count_reg != {CWIDTH{1'b1}})) begin
      count_next = count_reg + CWIDTH'(1);
    end
  end

  // Counter state with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/branch_resolve.sv
// Execute-stage branch resolution: carries fetched instructions through the
// D and X stage registers, compares the predicted next PC against the real
// one, redirects/flushes on a mispredict, trains the target buffer on taken
// branches and keeps branch / mispredict statistics.
module branch_resolve
  import rv_pipe_pkg::*;
#(
  parameter int AWIDTH = DEF_AWIDTH,
  parameter int CWIDTH = DEF_CWIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_f,
  input  logic [AWIDTH-1:0] PC_f,
  input  logic [AWIDTH-1:0] pred_f,
  input  logic              stall_d,
  input  logic              br_x,
  input  logic              taken_x,
  input  logic [AWIDTH-1:0] alu_out,
  output logic              redirect,
  output logic [AWIDTH-1:0] redirect_pc,
  output logic              flush,
  output logic              upd_en,
  output logic [AWIDTH-1:0] upd_pc,
  output logic [AWIDTH-1:0] upd_target,
  output logic [CWIDTH-1:0] br_cnt,
  output logic [CWIDTH-1:0] mis_cnt
);

  localparam int SW     = stage_width(AWIDTH);
  localparam int V_BIT  = stage_v_bit(AWIDTH);
  localparam int PC_LSB = stage_pc_lsb(AWIDTH);

  // Stage records
  logic [SW-1:0] f_rec;
  logic [SW-1:0] d_reg;
  logic [SW-1:0] d_next;
  logic [SW-1:0] x_reg;
  logic [SW-1:0] x_next;

  // Field views of the stage records
  logic              v_d;
  logic [AWIDTH-1:0] pc_d;
  logic              v_x;
  logic [AWIDTH-1:0] pc_x;
  logic [AWIDTH-1:0] pred_x;

  logic [AWIDTH-1:0] actual;
  logic              mispredict;

  logic [NUM_CNT-1:0] cnt_inc;
  logic [CWIDTH-1:0]  cnt_val [NUM_CNT];

  assign f_rec  = {valid_f, PC_f, pred_f};
  assign v_d    = d_reg[V_BIT];
  assign pc_d   = d_reg[V_BIT-1:PC_LSB];
  assign v_x    = x_reg[V_BIT];
  assign pc_x   = x_reg[V_BIT-1:PC_LSB];
  assign pred_x = x_reg[PC_LSB-1:0];

  // Resolve the true next PC of the X-stage instruction and compare it with
  // the prediction it was fetched under; bubbles never mispredict.  A
  // non-branch whose prediction differs from pc+4 (stale buffer hit) counts
  // as a mispredict as well.
  always_comb begin
    actual = pc_x + AWIDTH'(PC_INC);
    if (br_x && taken_x) begin
      actual = alu_out;
    end
    mispredict = v_x && (pred_x != actual);
  end

  // Next stage contents: a flush squashes D and X even while stalled; a
  // stall holds D and injects a bubble into X; otherwise the pipe advances.
  always_comb begin
    d_next = d_reg;
    x_next = x_reg;
    if (mispredict) begin
      d_next[V_BIT] = 1'b0;
      x_next[V_BIT] = 1'b0;
    end else if (stall_d) begin
      x_next[V_BIT] = 1'b0;
    end else begin
      d_next = f_rec;
      x_next = d_reg;
    end
  end

  // Stage registers; reset only needs to drop the valid bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      d_reg[V_BIT] <= 1'b0;
      x_reg[V_BIT] <= 1'b0;
    end else begin
      d_reg <= d_next;
      x_reg <= x_next;
    end
  end

  // Redirect, buffer-training and statistics-increment outputs.
  always_comb begin
    redirect            = mispredict;
    flush               = mispredict;
    redirect_pc         = actual;
    upd_en              = v_x && br_x && taken_x;
    upd_pc              = pc_x;
    upd_target          = alu_out;
    cnt_inc             = '0;
    cnt_inc[CNT_BR]     = v_x && br_x;
    cnt_inc[CNT_MIS]    = mispredict;
  end

  // Statistics counter bank
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
      sat_counter #(
        .CWIDTH(CWIDTH)
      ) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (cnt_inc[gi]),
        .count(cnt_val[gi])
      );
    end
  endgenerate

  assign br_cnt  = cnt_val[CNT_BR];
  assign mis_cnt = cnt_val[CNT_MIS];

endmodule

// File: tb/tb_branch_resolve.sv
// Bench for branch_resolve: a default-width instance and a 4-bit-counter
// instance share the same stimulus; a queue-free stage model predicts every
// output each cycle, plus directed vectors and multi-cycle sequences.
module tb_branch_resolve;

  localparam int AW  = 32;
  localparam int CW  = 16;
  localparam int CW4 = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          valid_f;
  logic [AW-1:0] PC_f;
  logic [AW-1:0] pred_f;
  logic          stall_d;
  logic          br_x;
  logic          taken_x;
  logic [AW-1:0] alu_out;

  logic          redirect, flush, upd_en;
  logic [AW-1:0] redirect_pc, upd_pc, upd_target;
  logic [CW-1:0] br_cnt, mis_cnt;

  logic          redirect4, flush4, upd_en4;
  logic [AW-1:0] redirect_pc4, upd_pc4, upd_target4;
  logic [CW4-1:0] br_cnt4, mis_cnt4;

  branch_resolve #(.AWIDTH(AW), .CWIDTH(CW)) dut (
    .clk(clk), .rst(rst), .valid_f(valid_f), .PC_f(PC_f), .pred_f(pred_f),
    .stall_d(stall_d), .br_x(br_x), .taken_x(taken_x), .alu_out(alu_out),
    .redirect(redirect), .redirect_pc(redirect_pc), .flush(flush),
    .upd_en(upd_en), .upd_pc(upd_pc), .upd_target(upd_target),
    .br_cnt(br_cnt), .mis_cnt(mis_cnt)
  );

  branch_resolve #(.AWIDTH(AW), .CWIDTH(CW4)) dut4 (
    .clk(clk), .rst(rst), .valid_f(valid_f), .PC_f(PC_f), .pred_f(pred_f),
    .stall_d(stall_d), .br_x(br_x), .taken_x(taken_x), .alu_out(alu_out),
    .redirect(redirect4), .redirect_pc(redirect_pc4), .flush(flush4),
    .upd_en(upd_en4), .upd_pc(upd_pc4), .upd_target(upd_target4),
    .br_cnt(br_cnt4), .mis_cnt(mis_cnt4)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Two instruction slots (D, X) and plain integer statistics.
  bit            m_dv, m_xv;
  logic [AW-1:0] m_dpc, m_dpred, m_xpc, m_xpred;
  int            m_br, m_mis, m_br4, m_mis4;

  function automatic int sat_inc(input int c, input int w);
    int top;
    top = (1 << w) - 1;
    return (c + 1 > top) ? top : c + 1;
  endfunction

  function automatic logic [AW-1:0] m_next_pc();
    if (br_x && taken_x) return alu_out;
    return m_xpc + 32'd4;
  endfunction

  function automatic bit m_mispredict();
    return m_xv && (m_xpred != m_next_pc());
  endfunction

  // Compare every output against the model in the middle of the cycle.
  task automatic settle();
    bit e_red, e_upd;
    @(negedge clk);
    e_red = m_mispredict();
    e_upd = m_xv && br_x && taken_x;
    check("redirect", redirect, e_red);
    check("flush", flush, e_red);
    check("upd_en", upd_en, e_upd);
    check("redirect4", redirect4, e_red);
    check("br_cnt", br_cnt, m_br);
    check("mis_cnt", mis_cnt, m_mis);
    check("br_cnt4", br_cnt4, m_br4);
    check("mis_cnt4", mis_cnt4, m_mis4);
    check("v_d", dut.v_d, m_dv);
    check("v_x", dut.v_x, m_xv);
    if (m_xv) check("redirect_pc", redirect_pc, m_next_pc());
    if (e_upd) begin
      check("upd_pc", upd_pc, m_xpc);
      check("upd_target", upd_target, alu_out);
    end
  endtask

  // Clock edge: update the model from the inputs that were present.
  task automatic advance();
    bit red;
    @(posedge clk);
    if (rst) begin
      m_dv = 0; m_xv = 0;
      m_br = 0; m_mis = 0; m_br4 = 0; m_mis4 = 0;
    end else begin
      red = m_mispredict();
      if (m_xv && br_x) begin
        m_br  = sat_inc(m_br, CW);
        m_br4 = sat_inc(m_br4, CW4);
      end
      if (red) begin
        m_mis  = sat_inc(m_mis, CW);
        m_mis4 = sat_inc(m_mis4, CW4);
        m_dv = 0; m_xv = 0;
      end else if (stall_d) begin
        m_xv = 0;
      end else begin
        m_xv = m_dv; m_xpc = m_dpc; m_xpred = m_dpred;
        m_dv = valid_f; m_dpc = PC_f; m_dpred = pred_f;
      end
    end
    #1;
  endtask

  task automatic tick();
    settle();
    advance();
  endtask

  task automatic idle_inputs();
    valid_f = 0; stall_d = 0; br_x = 0; taken_x = 0;
    PC_f = '0; pred_f = '0; alu_out = '0;
  endtask

  task automatic drain();
    idle_inputs();
    tick();
    tick();
  endtask

  task automatic do_reset();
    rst = 1;
    idle_inputs();
    advance();
    rst = 0;
  endtask

  // Fetch one instruction; after this returns it sits in X.
  task automatic feed(input logic [AW-1:0] pc, input logic [AW-1:0] pred);
    valid_f = 1; PC_f = pc; pred_f = pred;
    tick();
    valid_f = 0;
    tick();
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    string         name;
    logic [AW-1:0] pc;
    logic [AW-1:0] pred;
    bit            br;
    bit            taken;
    logic [AW-1:0] alu;
    bit            e_red;
    logic [AW-1:0] e_rpc;
    bit            e_upd;
    logic [AW-1:0] e_upc;
    logic [AW-1:0] e_utgt;
    int            e_dbr;
    int            e_dmis;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int br0, mis0;

    vecs[0] = '{"correct",   32'h100,      32'h104, 0, 0, 32'hDEAD0000, 0, 32'h104, 0, 32'h0,   32'h0,   0, 0};
    vecs[1] = '{"taken_mis", 32'h200,      32'h204, 1, 1, 32'h180,      1, 32'h180, 1, 32'h200, 32'h180, 1, 1};
    vecs[2] = '{"nt_mis",    32'h300,      32'h3A0, 1, 0, 32'h5555,     1, 32'h304, 0, 32'h0,   32'h0,   1, 1};
    vecs[3] = '{"stale_hit", 32'h500,      32'h600, 0, 0, 32'h600,      1, 32'h504, 0, 32'h0,   32'h0,   0, 1};
    vecs[4] = '{"wrap_ok",   32'hFFFFFFFC, 32'h0,   0, 0, 32'h1234,     0, 32'h0,   0, 32'h0,   32'h0,   0, 0};
    vecs[5] = '{"taken_ok",  32'h700,      32'h840, 1, 1, 32'h840,      0, 32'h840, 1, 32'h700, 32'h840, 1, 0};
    vecs[6] = '{"wrap_mis",  32'hFFFFFFFC, 32'h4,   0, 0, 32'h4,        1, 32'h0,   0, 32'h0,   32'h0,   0, 1};

    rst = 1;
    idle_inputs();
    advance();
    advance();
    rst = 0;

    // Post-reset state
    settle();
    check("rst_redirect", redirect, 1'b0);
    check("rst_flush", flush, 1'b0);
    check("rst_upd_en", upd_en, 1'b0);
    check("rst_br_cnt", br_cnt, 16'd0);
    check("rst_mis_cnt", mis_cnt, 16'd0);
    advance();

    // Table-driven single-instruction vectors
    for (int i = 0; i < 7; i++) begin
      drain();
      feed(vecs[i].pc, vecs[i].pred);
      br_x = vecs[i].br; taken_x = vecs[i].taken; alu_out = vecs[i].alu;
      settle();
      check({vecs[i].name, "_redirect"}, redirect, vecs[i].e_red);
      check({vecs[i].name, "_redirect_pc"}, redirect_pc, vecs[i].e_rpc);
      check({vecs[i].name, "_upd_en"}, upd_en, vecs[i].e_upd);
      if (vecs[i].e_upd) begin
        check({vecs[i].name, "_upd_pc"}, upd_pc, vecs[i].e_upc);
        check({vecs[i].name, "_upd_target"}, upd_target, vecs[i].e_utgt);
      end
      br0 = int'(br_cnt); mis0 = int'(mis_cnt);
      advance();
      idle_inputs();
      settle();
      check({vecs[i].name, "_br_cnt"}, br_cnt, 64'(br0 + vecs[i].e_dbr));
      check({vecs[i].name, "_mis_cnt"}, mis_cnt, 64'(mis0 + vecs[i].e_dmis));
      check({vecs[i].name, "_next_redirect"}, redirect, 1'b0);
      if (vecs[i].e_red) begin
        check({vecs[i].name, "_squash_v_d"}, dut.v_d, 1'b0);
        check({vecs[i].name, "_squash_v_x"}, dut.v_x, 1'b0);
      end
      advance();
    end

    // Stall: 0x400 held in D for two cycles, X sees two bubbles
    drain();
    valid_f = 1; PC_f = 32'h400; pred_f = 32'h404;
    tick();
    stall_d = 1; valid_f = 1; PC_f = 32'h900; pred_f = 32'h904;
    br_x = 1; taken_x = 1; alu_out = 32'h404;
    for (int k = 0; k < 2; k++) begin
      settle();
      check("stall_upd_en", upd_en, 1'b0);
      if (k > 0) check("stall_bubble1", dut.v_x, 1'b0);
      check("stall_hold_pc_d", dut.pc_d, 32'h400);
      advance();
    end
    stall_d = 0; valid_f = 0;
    settle();
    check("stall_bubble2", dut.v_x, 1'b0);
    check("stall_d_retained", dut.pc_d, 32'h400);
    check("stall_v_d", dut.v_d, 1'b1);
    advance();
    settle();
    check("stall_release_upd_en", upd_en, 1'b1);
    check("stall_release_upd_pc", upd_pc, 32'h400);
    check("stall_release_redirect", redirect, 1'b0);
    advance();

    // Stall together with redirect: flush wins
    drain();
    valid_f = 1; PC_f = 32'h600; pred_f = 32'h700;
    tick();
    valid_f = 1; PC_f = 32'h610; pred_f = 32'h614;
    tick();
    valid_f = 0; stall_d = 1;
    settle();
    check("stallflush_redirect", redirect, 1'b1);
    check("stallflush_pc", redirect_pc, 32'h604);
    advance();
    settle();
    check("stallflush_v_d", dut.v_d, 1'b0);
    check("stallflush_v_x", dut.v_x, 1'b0);
    check("stallflush_once", redirect, 1'b0);
    advance();
    stall_d = 0;

    // Saturation: 20 mispredicts against a 4-bit counter
    do_reset();
    for (int n = 0; n < 20; n++) begin
      feed(32'h1000 + 32'(n * 16), 32'h2000);
      settle();
      check("sat_redirect", redirect, 1'b1);
      advance();
    end
    idle_inputs();
    settle();
    check("sat_mis_cnt4", mis_cnt4, 4'hF);
    check("sat_mis_cnt", mis_cnt, 16'd20);
    check("sat_br_cnt", br_cnt, 16'd0);
    advance();

    // Reset in the middle of a redirect with another instruction in D
    drain();
    valid_f = 1; PC_f = 32'h800; pred_f = 32'h900;
    br_x = 0;
    tick();
    valid_f = 1; PC_f = 32'h810; pred_f = 32'h814;
    tick();
    valid_f = 1; PC_f = 32'h820; pred_f = 32'h824;
    rst = 1;
    settle();
    check("midrst_pre_redirect", redirect, 1'b1);
    advance();
    rst = 0; valid_f = 0;
    settle();
    check("midrst_v_d", dut.v_d, 1'b0);
    check("midrst_v_x", dut.v_x, 1'b0);
    check("midrst_redirect", redirect, 1'b0);
    check("midrst_br_cnt", br_cnt, 16'd0);
    check("midrst_mis_cnt", mis_cnt, 16'd0);
    check("midrst_mis_cnt4", mis_cnt4, 4'd0);
    advance();

    // Randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      rst     = ($urandom_range(0, 59) == 0);
      valid_f = $urandom_range(0, 3) != 0;
      PC_f    = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 3) == 0) PC_f = 32'hFFFF_FFFC;
      pred_f  = ($urandom_range(0, 2) != 0) ? PC_f + 32'd4 : ($urandom & 32'hFFFF_FFFC);
      stall_d = $urandom_range(0, 4) == 0;
      br_x    = $urandom_range(0, 1) == 1;
      taken_x = $urandom_range(0, 1) == 1;
      alu_out = ($urandom_range(0, 1) == 1) ? m_xpred : ($urandom & 32'hFFFF_FFFC);
      tick();
    end
    rst = 0;
    idle_inputs();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
